decode_hazard_ctrl: RTL and testbench
=====================================

// Module: decode_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the decode stage: detects load-use hazards between the
//  instruction in ID and in-flight loads, and drives stall/bubble/flush/freeze
//  for PC, IF/ID and ID/EX. Consumes the decoded register fields and the
//  load/we flags produced by rv32i_decoder.
//  Sits beside the decoder; its outputs gate the IF/ID and ID/EX pipeline registers.
// PARAMETERS
//  LOAD_USE_CYCLES  1  cycles a load result is unavailable to ID after issue to EX (1..4)
//  REG_AW           5  register address width
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-high reset
//  id_valid     in   1       ID holds a valid instruction
//  id_rs1       in   REG_AW  source 1 address (a_select)
//  id_rs2       in   REG_AW  source 2 address (b_select)
//  id_use_rs1   in   1       instruction reads rs1
//  id_use_rs2   in   1       instruction reads rs2
//  id_rd        in   REG_AW  destination address (d_addr)
//  id_we        in   1       register write enable
//  id_is_load   in   1       instruction is a load
//  ex_redirect  in   1       taken branch/jump resolved in EX
//  mem_ready    in   1       data memory ready; 0 = memory wait
//  pc_stall     out  1       hold PC
//  ifid_stall   out  1       hold IF/ID register
//  idex_bubble  out  1       load NOP into ID/EX
//  ifid_flush   out  1       clear IF/ID register
//  idex_flush   out  1       clear ID/EX register
//  pipe_freeze  out  1       hold every stage register
//  hz_state     out  2       FSM state (debug)
// BEHAVIOUR
//  - Async reset: all outputs 0, hz_state=RUN, scoreboard cleared.
//  - Scoreboard: LOAD_USE_CYCLES entries {valid, rd}, shift register.
//    Entry0 <= {advance & id_is_load & id_we & (id_rd!=0), id_rd}.
//    Shifts on every non-frozen cycle; holds while pipe_freeze=1.
//  - hazard = id_valid & any valid entry k with rd==id_rs1&id_use_rs1 or rd==id_rs2&id_use_rs2.
//    rd=0 is never recorded.
//  - Priority (combinational, same cycle): freeze > redirect > hazard.
//    freeze   (mem_ready=0): pipe_freeze=pc_stall=ifid_stall=1; bubble/flush=0.
//    redirect: ifid_flush=idex_flush=1; stall/bubble=0.
//              Scoreboard still shifts; older loads are kept.
//    hazard:   pc_stall=ifid_stall=idex_bubble=1.
//  - advance = id_valid & !freeze & !redirect & !hazard.
//  - FSM (registered, next state from current-cycle condition):
//    RUN=0, LU_STALL=1, FREEZE=2.
//    Any state -> FREEZE if freeze, -> LU_STALL if hazard, else -> RUN.
//    Redirect always -> RUN.
//  - A stall lasts until the matching entry shifts out: at most LOAD_USE_CYCLES cycles.
//  - Back-to-back loads: each occupies its own entry; no overwrite.
//  - Reset mid-stall: outputs drop immediately (async). Scoreboard empty on release.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds ports stall_cnt out 32 and flush_cnt out 32.
//    stall_cnt +1 per hazard cycle; flush_cnt +1 per redirect cycle.
//    Both wrap at 2^32 and reset to 0.
//  HAZARD_PERF_CNT_EN undefined: ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  hazard_pkg: hz_state_e {RUN, LU_STALL, FREEZE}, REG_AW_DEF=5, sb_entry_t {valid, rd}.
//  Sub-module load_scoreboard: shift register plus parallel rs1/rs2 match; outputs hazard.
// TESTING
//  1 LOAD_USE_CYCLES=1: lw x5 advances, then add x6,x5,x1 in ID (use_rs1)
//    -> exactly 1 cycle pc_stall=ifid_stall=idex_bubble=1, hz_state=LU_STALL, then advance.
//  2 lw x0 followed by a consumer of x0 -> no stall.
//    lw x5 followed by a consumer with id_use_rs1=0 and rs1=5 -> no stall.
//  3 mem_ready=0 for 3 cycles while a load is pending
//    -> pipe_freeze=1 for 3 cycles, hz_state=FREEZE, scoreboard unchanged, stall resumes afterwards.
//  4 ex_redirect=1 in the same cycle as a hazard
//    -> ifid_flush=idex_flush=1, idex_bubble=0, next hz_state=RUN.
//  5 LOAD_USE_CYCLES=2: lw x7 then immediate consumer -> 2 stall cycles.
//    Consumer one instruction later -> 1 stall cycle.
//  6 Assert reset during LU_STALL -> all outputs 0 in the same cycle.
//    After release, a consumer of x5 does not stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard sequencer: FSM states and
// load scoreboard entry layout.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2
    } hz_state_e;

    // One in-flight load whose result is not yet visible to ID.
    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Decode-side bundle: decoded register fields and flags going into the
// hazard sequencer, pipeline control coming back out.
interface decode_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_we;
    logic              id_is_load;
    logic              ex_redirect;
    logic              mem_ready;
    logic              pc_stall;
    logic              ifid_stall;
    logic              idex_bubble;
    logic              ifid_flush;
    logic              idex_flush;
    logic              pipe_freeze;
    logic [1:0]        hz_state;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_we, id_is_load, ex_redirect, mem_ready,
        input  pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
               pipe_freeze, hz_state
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_we, id_is_load, ex_redirect, mem_ready,
        output pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
               pipe_freeze, hz_state
    );
endinterface

// File: rtl/load_scoreboard.sv
// Shift register of recently issued loads plus a parallel compare against
// the ID source operands. Entry k holds a load issued k+1 cycles ago.
module load_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH  = 1,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              push,
    input  logic [REG_AW-1:0] push_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    output logic              hazard
);
    sb_entry_t [DEPTH-1:0] sb;

    // Age loads by one slot each live cycle; x0 never creates a dependency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb <= '0;
        end else if (shift_en) begin
            sb[0].valid <= push && (push_rd != '0);
            sb[0].rd    <= REG_AW_DEF'(push_rd);
            for (int k = 1; k < DEPTH; k++)
                sb[k] <= sb[k-1];
        end
    end

    // Any live entry matching a source operand that is actually read.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sb[k].valid &&
                ((use_rs1 && sb[k].rd == REG_AW_DEF'(rs1)) ||
                 (use_rs2 && sb[k].rd == REG_AW_DEF'(rs2))))
                hazard = id_valid;
        end
    end
endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage pipeline sequencer: load-use stall, redirect flush and
// memory-wait freeze for PC, IF/ID and ID/EX.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall/flush counters.
module decode_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int REG_AW          = REG_AW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    decode_hazard_ctrl_if.slave  bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
`endif
);
    hz_state_e state;
    logic      hazard, freeze, redirect, hz_act, advance;

    // Priority: memory wait beats redirect beats load-use.
    assign freeze   = !bus.mem_ready;
    assign redirect = bus.ex_redirect && !freeze;
    assign hz_act   = hazard && !freeze && !bus.ex_redirect;
    assign advance  = bus.id_valid && !freeze && !bus.ex_redirect && !hazard;

    load_scoreboard #(
        .DEPTH  (LOAD_USE_CYCLES),
        .REG_AW (REG_AW)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .shift_en (!freeze),
        .push     (advance && bus.id_is_load && bus.id_we),
        .push_rd  (bus.id_rd),
        .id_valid (bus.id_valid),
        .rs1      (bus.id_rs1),
        .rs2      (bus.id_rs2),
        .use_rs1  (bus.id_use_rs1),
        .use_rs2  (bus.id_use_rs2),
        .hazard   (hazard)
    );

    // Controls are combinational; gating with reset makes them drop at once.
    assign bus.pipe_freeze = !reset && freeze;
    assign bus.pc_stall    = !reset && (freeze || hz_act);
    assign bus.ifid_stall  = !reset && (freeze || hz_act);
    assign bus.idex_bubble = !reset && hz_act;
    assign bus.ifid_flush  = !reset && redirect;
    assign bus.idex_flush  = !reset && redirect;
    assign bus.hz_state    = state;

    // Debug state tracks which condition won in the previous cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                state <= RUN;
        else if (freeze)          state <= FREEZE;
        else if (bus.ex_redirect) state <= RUN;
        else if (hazard)          state <= LU_STALL;
        else                      state <= RUN;
    end

`ifdef HAZARD_PERF_CNT_EN
    // Free-running event counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz_act)   stall_cnt <= stall_cnt + 32'd1;
            if (redirect) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench: one instance with LOAD_USE_CYCLES=1, one with 2.
module tb_decode_hazard_ctrl;
    import hazard_pkg::*;

    localparam logic [5:0] NONE  = 6'b000000;
    localparam logic [5:0] STALL = 6'b111000;
    localparam logic [5:0] FRZ   = 6'b110001;
    localparam logic [5:0] FLS   = 6'b000110;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    decode_hazard_ctrl_if #(.REG_AW(5)) b1 ();
    decode_hazard_ctrl_if #(.REG_AW(5)) b2 ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc1, fc1, sc2, fc2;
`endif

    decode_hazard_ctrl #(.LOAD_USE_CYCLES(1), .REG_AW(5)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt (sc1), .flush_cnt (fc1)
`endif
    );

    decode_hazard_ctrl #(.LOAD_USE_CYCLES(2), .REG_AW(5)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt (sc2), .flush_cnt (fc2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctl(input int w);
        if (w == 1)
            return {b1.pc_stall, b1.ifid_stall, b1.idex_bubble,
                    b1.ifid_flush, b1.idex_flush, b1.pipe_freeze};
        return {b2.pc_stall, b2.ifid_stall, b2.idex_bubble,
                b2.ifid_flush, b2.idex_flush, b2.pipe_freeze};
    endfunction

    function automatic logic [1:0] st(input int w);
        return (w == 1) ? b1.hz_state : b2.hz_state;
    endfunction

    task automatic drive(input int w, input bit v, input int rs1, input int rs2,
                         input bit u1, input bit u2, input int rd, input bit we,
                         input bit ld, input bit redir, input bit mrdy);
        if (w == 1) begin
            b1.id_valid = v; b1.id_rs1 = 5'(rs1); b1.id_rs2 = 5'(rs2);
            b1.id_use_rs1 = u1; b1.id_use_rs2 = u2; b1.id_rd = 5'(rd);
            b1.id_we = we; b1.id_is_load = ld; b1.ex_redirect = redir;
            b1.mem_ready = mrdy;
        end else begin
            b2.id_valid = v; b2.id_rs1 = 5'(rs1); b2.id_rs2 = 5'(rs2);
            b2.id_use_rs1 = u1; b2.id_use_rs2 = u2; b2.id_rd = 5'(rd);
            b2.id_we = we; b2.id_is_load = ld; b2.ex_redirect = redir;
            b2.mem_ready = mrdy;
        end
    endtask

    task automatic idle(input int w);
        drive(w, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // lw rd, 0(x1)
    task automatic lw(input int w, input int rd);
        drive(w, 1, 1, 0, 1, 0, rd, 1, 1, 0, 1);
    endtask

    // Check controls and debug state mid-cycle, then move to the next cycle.
    task automatic cyc(input int w, input logic [5:0] ec, input logic [1:0] es, input string tag);
        @(negedge clk);
        chk({tag, ".ctl"}, 32'(ctl(w)), 32'(ec));
        chk({tag, ".st"},  32'(st(w)),  32'(es));
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        idle(1);
        idle(2);
        #2;
        chk("rst1.ctl", 32'(ctl(1)), 32'(NONE));
        chk("rst1.st",  32'(st(1)),  32'(RUN));
        chk("rst2.ctl", 32'(ctl(2)), 32'(NONE));
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: lw x5 ; add x6,x5,x1 -> one stall cycle
        lw(1, 5);                              cyc(1, NONE, RUN, "t1_lw");
        drive(1, 1, 5, 1, 1, 1, 6, 1, 0, 0, 1); cyc(1, STALL, RUN, "t1_stall");
        cyc(1, NONE, LU_STALL, "t1_adv");
        idle(1);                               cyc(1, NONE, RUN, "t1_idle");

        // 2: x0 destination and unused rs1 never stall
        drive(1, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1); cyc(1, NONE, RUN, "t2_lwx0");
        drive(1, 1, 0, 0, 1, 0, 6, 1, 0, 0, 1); cyc(1, NONE, RUN, "t2_usex0");
        lw(1, 5);                              cyc(1, NONE, RUN, "t2_lw5");
        drive(1, 1, 5, 3, 0, 1, 6, 1, 0, 0, 1); cyc(1, NONE, RUN, "t2_nouse");

        // 3: three-cycle memory wait over a pending load, stall afterwards
        lw(1, 5);                              cyc(1, NONE, RUN, "t3_lw");
        drive(1, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0); cyc(1, FRZ, RUN, "t3_f0");
        cyc(1, FRZ, FREEZE, "t3_f1");
        cyc(1, FRZ, FREEZE, "t3_f2");
        drive(1, 1, 5, 1, 1, 1, 6, 1, 0, 0, 1); cyc(1, STALL, FREEZE, "t3_stall");
        cyc(1, NONE, LU_STALL, "t3_adv");
        idle(1);                               cyc(1, NONE, RUN, "t3_idle");

        // 4: redirect in a hazard cycle flushes instead of bubbling
        lw(1, 5);                              cyc(1, NONE, RUN, "t4_lw");
        drive(1, 1, 5, 1, 1, 1, 6, 1, 0, 1, 1); cyc(1, FLS, RUN, "t4_redir");
        idle(1);                               cyc(1, NONE, RUN, "t4_next");
        drive(1, 1, 5, 1, 1, 1, 6, 1, 0, 1, 0); cyc(1, FRZ, RUN, "t4_frzwin");
        idle(1);                               cyc(1, NONE, FREEZE, "t4_after");
        cyc(1, NONE, RUN, "t4_idle");

        // 5: two-cycle load latency
        lw(2, 7);                              cyc(2, NONE, RUN, "t5_lw");
        drive(2, 1, 1, 7, 1, 1, 9, 1, 0, 0, 1); cyc(2, STALL, RUN, "t5_s0");
        cyc(2, STALL, LU_STALL, "t5_s1");
        cyc(2, NONE, LU_STALL, "t5_adv");
        lw(2, 7);                              cyc(2, NONE, RUN, "t5_lw_b");
        drive(2, 1, 1, 2, 1, 1, 8, 1, 0, 0, 1); cyc(2, NONE, RUN, "t5_indep");
        drive(2, 1, 7, 0, 1, 0, 9, 1, 0, 0, 1); cyc(2, STALL, RUN, "t5_late");
        cyc(2, NONE, LU_STALL, "t5_late_adv");
        // back-to-back loads keep separate entries
        lw(2, 7);                              cyc(2, NONE, RUN, "t5_bb7");
        lw(2, 8);                              cyc(2, NONE, RUN, "t5_bb8");
        drive(2, 1, 8, 7, 1, 1, 9, 1, 0, 0, 1); cyc(2, STALL, RUN, "t5_bb_s0");
        cyc(2, STALL, LU_STALL, "t5_bb_s1");
        cyc(2, NONE, LU_STALL, "t5_bb_adv");
        idle(2);                               cyc(2, NONE, RUN, "t5_idle");

        // 6: reset during a stall drops everything at once
        lw(2, 7);                              cyc(2, NONE, RUN, "t6_lw");
        drive(2, 1, 7, 0, 1, 0, 9, 1, 0, 0, 1); cyc(2, STALL, RUN, "t6_s0");
        @(negedge clk);
        chk("t6_pre.ctl", 32'(ctl(2)), 32'(STALL));
        chk("t6_pre.st",  32'(st(2)),  32'(LU_STALL));
        #1 reset = 1'b1;
        #1;
        chk("t6_rst.ctl", 32'(ctl(2)), 32'(NONE));
        chk("t6_rst.st",  32'(st(2)),  32'(RUN));
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(2, NONE, RUN, "t6_post7");
        drive(1, 1, 5, 0, 1, 0, 6, 1, 0, 0, 1); cyc(1, NONE, RUN, "t6_post5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
